flappy_game_ctrl: RTL and testbench

FLAPPY_GAME_CTRL -- requirements
Module: flappy_game_ctrl

---
 rtl/flappy_game_ctrl.sv | 130 +++++++++++++
 tb/tb_flappy_game_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: frame-stepped Flappy Bird controller with bird physics, scrolling pipe, collision and score
module flappy_game_ctrl #(
  parameter int SCREEN_H   = 480,
  parameter int SCREEN_W   = 640,
  parameter int BIRD_X     = 305,
  parameter int BIRD_SIZE  = 30,
  parameter int PIPE_W     = 50,
  parameter int GAP_H      = 140,
  parameter int GRAVITY    = 1,
  parameter int FLAP_V     = 8,
  parameter int VMAX       = 12,
  parameter int PIPE_SPEED = 2,
  parameter int OVER_HOLD  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       flap,
  output logic       start_game,
  output logic       end_game,
  output logic [9:0] bird_y,
  output logic [9:0] pipe_x,
  output logic [8:0] gap_top,
  output logic [7:0] score
);
  typedef enum logic [1:0] {START, PLAY, OVER} state_t;
  localparam int HW = $clog2(OVER_HOLD + 1);
  localparam logic [9:0] Y0 = 10'd225;
  localparam logic [9:0] FLOOR = 10'(SCREEN_H - BIRD_SIZE);
  localparam logic [9:0] PX0 = 10'(SCREEN_W);
  localparam logic [9:0] SPD = 10'(PIPE_SPEED);
  localparam logic [9:0] PASS = 10'(BIRD_X - PIPE_W);
  localparam logic [9:0] BX_R = 10'(BIRD_X + BIRD_SIZE);
  localparam logic [8:0] GT0 = 9'd205;
  localparam logic signed [11:0] GRV = 12'(GRAVITY);
  localparam logic signed [11:0] FLV = 12'(FLAP_V);
  localparam logic signed [11:0] VMX = 12'(VMAX);
  localparam logic [HW-1:0] HOLD_MAX = HW'(OVER_HOLD);
  state_t state, state_n;
  logic flap_q, pending, pend_now, hold_done, hit, collide, pass_pipe, wrap;
  logic [7:0] lfsr, sc_n, sc_d;
  logic [HW-1:0] hold, hold_n;
  logic signed [5:0] vel, vel_d;
  logic signed [11:0] vel_w, v_inc, v_next, y_new;
  logic [9:0] by_n, by_d, px_n, px_d;
  logic [8:0] gt_n, gt_d;
  logic [10:0] px_end, by_end, gap_end;
  // a press landing in the same cycle as the tick still counts for that frame
  assign pend_now = pending | (flap & ~flap_q);
  assign hold_done = hold == HOLD_MAX;
  assign start_game = state == START;
  assign end_game = state == OVER;
  assign vel_w = {{6{vel[5]}}, vel};
  assign v_inc = vel_w + GRV;
  assign v_next = pend_now ? -FLV : (v_inc > VMX ? VMX : v_inc);
  assign y_new = $signed({2'b00, bird_y}) + v_next;
  assign hit = y_new[11] || y_new > $signed({2'b00, FLOOR});
  assign by_n = y_new[11] ? 10'd0 : (y_new > $signed({2'b00, FLOOR}) ? FLOOR : y_new[9:0]);
  assign wrap = pipe_x < SPD;
  assign px_n = wrap ? PX0 : pipe_x - SPD;
  assign gt_n = wrap ? 9'd40 + {1'b0, lfsr} : gap_top;
  assign pass_pipe = pipe_x >= PASS && px_n < PASS;
  assign sc_n = score + 8'(pass_pipe && score != 8'hFF);
  assign px_end = {1'b0, px_n} + 11'(PIPE_W);
  assign by_end = {1'b0, by_n} + 11'(BIRD_SIZE);
  assign gap_end = {2'b00, gt_n} + 11'(GAP_H);
  assign collide = px_n < BX_R && px_end > 11'(BIRD_X) && ({1'b0, by_n} < {2'b00, gt_n} || by_end > gap_end);
  // per-frame game step: everything holds unless frame_tick is high
  always_comb begin
    state_n = state;
    vel_d = vel;
    by_d = bird_y;
    px_d = pipe_x;
    gt_d = gap_top;
    sc_d = score;
    hold_n = hold;
    if (frame_tick)
      case (state)
        START: if (pend_now) begin
          state_n = PLAY;
          vel_d = v_next[5:0];
          by_d = by_n;
        end
        PLAY: begin
          state_n = hit || collide ? OVER : PLAY;
          vel_d = v_next[5:0];
          by_d = by_n;
          px_d = px_n;
          gt_d = gt_n;
          sc_d = sc_n;
          hold_n = '0;
        end
        OVER: if (hold_done && pend_now) begin
          state_n = START;
          vel_d = '0;
          by_d = Y0;
          px_d = PX0;
          gt_d = GT0;
          sc_d = '0;
          hold_n = '0;
        end else hold_n = hold_done ? hold : hold + HW'(1);
        default: state_n = START;
      endcase
  end
  // state, physics and flap bookkeeping registers; the LFSR free-runs every cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= START;
      vel <= '0;
      bird_y <= Y0;
      pipe_x <= PX0;
      gap_top <= GT0;
      score <= '0;
      hold <= '0;
      flap_q <= 1'b0;
      pending <= 1'b0;
      lfsr <= 8'hA5;
    end else begin
      state <= state_n;
      vel <= vel_d;
      bird_y <= by_d;
      pipe_x <= px_d;
      gap_top <= gt_d;
      score <= sc_d;
      hold <= hold_n;
      flap_q <= flap;
      pending <= !frame_tick && !(state == OVER && !hold_done) && pend_now;
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: scoreboard bench over three parameterisations of the game controller
module tb_flappy_game_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ft [3] = '{default: 1'b0};
  logic fl [3] = '{default: 1'b0};
  logic sg [3], eg [3];
  logic [9:0] by [3], px [3];
  logic [8:0] gt [3];
  logic [7:0] sc [3];
  logic [7:0] lfsr_m;
  int checks = 0, errors = 0;
  typedef struct {string name; int d; int sg; int eg; int by; int px; int gt; int sc;} exp_t;
  exp_t q[$];
  exp_t e;
  int m_y, m_v, m_px, m_gt, m_sc;
  always #5 clk = ~clk;
  flappy_game_ctrl u0 (.clk(clk), .rst_n(rst_n), .frame_tick(ft[0]), .flap(fl[0]), .start_game(sg[0]),
    .end_game(eg[0]), .bird_y(by[0]), .pipe_x(px[0]), .gap_top(gt[0]), .score(sc[0]));
  flappy_game_ctrl #(.SCREEN_W(340), .PIPE_SPEED(100), .GRAVITY(0), .FLAP_V(0)) u1 (.clk(clk), .rst_n(rst_n),
    .frame_tick(ft[1]), .flap(fl[1]), .start_game(sg[1]), .end_game(eg[1]), .bird_y(by[1]), .pipe_x(px[1]),
    .gap_top(gt[1]), .score(sc[1]));
  flappy_game_ctrl #(.SCREEN_W(360), .GRAVITY(0), .FLAP_V(1)) u2 (.clk(clk), .rst_n(rst_n),
    .frame_tick(ft[2]), .flap(fl[2]), .start_game(sg[2]), .end_game(eg[2]), .bird_y(by[2]), .pipe_x(px[2]),
    .gap_top(gt[2]), .score(sc[2]));
  // reference LFSR: x^8+x^6+x^5+x^4+1, seed A5
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_m <= 8'hA5;
    else lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  task automatic chk(string n, int d, string f, int act, int want);
    if (want < 0) return;
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s.%s dut%0d got %0d want %0d", n, f, d, act, want);
    end
  endtask
  // monitor: drains the scoreboard away from the active edge
  always @(negedge clk)
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, e.d, "start_game", int'(sg[e.d]), e.sg);
      chk(e.name, e.d, "end_game", int'(eg[e.d]), e.eg);
      chk(e.name, e.d, "bird_y", int'(by[e.d]), e.by);
      chk(e.name, e.d, "pipe_x", int'(px[e.d]), e.px);
      chk(e.name, e.d, "gap_top", int'(gt[e.d]), e.gt);
      chk(e.name, e.d, "score", int'(sc[e.d]), e.sc);
    end
  task automatic push(string n, int d, int s, int en, int b, int p, int g, int c);
    exp_t x;
    x.name = n; x.d = d; x.sg = s; x.eg = en; x.by = b; x.px = p; x.gt = g; x.sc = c;
    q.push_back(x);
  endtask
  task automatic tick(int d, bit f, output logic [7:0] l);
    @(posedge clk); #1;
    ft[d] = 1'b1; fl[d] = f; l = lfsr_m;
    @(posedge clk); #1;
    ft[d] = 1'b0; fl[d] = 1'b0;
  endtask
  task automatic press(int d);
    @(posedge clk); #1; fl[d] = 1'b1;
    @(posedge clk); #1; fl[d] = 1'b0;
  endtask
  task automatic do_reset(bit mid);
    @(posedge clk); #1; rst_n = 1'b0;
    if (mid) push("mid_reset", 0, 1, 0, 225, 640, 205, 0);
    m_y = 225; m_v = 0; m_px = 640; m_gt = 205; m_sc = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic start0();
    logic [7:0] l;
    tick(0, 1'b1, l);
    m_v = -8; m_y = 217;
    push("start_flap", 0, 0, 0, 217, 640, 205, 0);
  endtask
  // default-parameter model of one PLAY frame on dut0
  task automatic g_tick(string n, bit f);
    logic [7:0] l;
    int old;
    bit over;
    tick(0, f, l);
    m_v = f ? -8 : (m_v + 1 > 12 ? 12 : m_v + 1);
    m_y = m_y + m_v;
    over = 0;
    if (m_y < 0) begin m_y = 0; over = 1; end
    else if (m_y > 450) begin m_y = 450; over = 1; end
    old = m_px;
    if (m_px < 2) begin m_px = 640; m_gt = 40 + int'(l); end
    else m_px = m_px - 2;
    if (old >= 255 && m_px < 255 && m_sc < 255) m_sc++;
    if (m_px < 335 && m_px + 50 > 305 && (m_y < m_gt || m_y + 30 > m_gt + 140)) over = 1;
    push(n, 0, 0, int'(over), m_y, m_px, m_gt, m_sc);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] l;
    int p, g, s, old;
    do_reset(1'b0);
    push("reset", 0, 1, 0, 225, 640, 205, 0);
    push("reset", 1, 1, 0, 225, 340, 205, 0);
    push("reset", 2, 1, 0, 225, 360, 205, 0);
    start0();
    for (int k = 1; k <= 330; k++) begin
      g_tick("play", m_y >= 270);
      if (k == 1) push("rise1", 0, -1, -1, 210, 638, -1, -1);
      if (k == 2) push("rise2", 0, -1, -1, 204, 636, -1, -1);
      if (k == 193) push("score_pass", 0, 0, 0, -1, 254, -1, 1);
    end
    do_reset(1'b1);
    start0();
    for (int k = 1; k <= 36; k++) begin
      g_tick("fall", 1'b0);
      if (k == 20) push("vcap20", 0, -1, -1, 267, -1, -1, -1);
      if (k == 21) push("vcap21", 0, -1, -1, 279, -1, -1, -1);
    end
    push("floor", 0, 0, 1, 450, 568, -1, 0);
    for (int i = 1; i <= 60; i++) begin
      if (i == 30) press(0);
      tick(0, i == 10, l);
      push("over_hold", 0, 0, 1, 450, 568, -1, 0);
    end
    tick(0, 1'b1, l);
    push("restart", 0, 1, 0, 225, 640, -1, 0);
    tick(0, 1'b0, l);
    push("start_idle", 0, 1, 0, 225, 640, -1, 0);
    do_reset(1'b0);
    tick(2, 1'b1, l);
    push("gap_start", 2, 0, 0, 224, 360, 205, 0);
    for (int n = 2; n <= 21; n++) begin
      tick(2, 1'b0, l);
      push(n == 21 ? "gap_edge" : "gap_in", 2, 0, int'(n == 21), 225 - n, 360 - 2 * (n - 1), 205, 0);
    end
    tick(1, 1'b1, l);
    push("sat_start", 1, 0, 0, 225, 340, 205, 0);
    p = 340; g = 205; s = 0;
    for (int k = 1; k <= 1040; k++) begin
      tick(1, 1'b0, l);
      old = p;
      if (p < 100) begin p = 340; g = 40 + int'(l); end
      else p = p - 100;
      if (old >= 255 && p < 255 && s < 255) s++;
      push("sat", 1, 0, 0, 225, p, g, s);
    end
    push("sat_hold", 1, -1, -1, -1, -1, -1, 255);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
